// File: rtl/mac_unit_pkg.sv
// Shared constants for the multiply-accumulate datapath element.
package mac_unit_pkg;

    localparam int unsigned IWIDTH = 4;
    localparam int unsigned SWIDTH = 10;

    // Width of the full-precision product of two operands of width w.
    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned iwidth x iwidth -> 2*iwidth full-precision multiplier.
module mac_mult
    import mac_unit_pkg::*;
#(
    parameter int unsigned iwidth = IWIDTH
) (
    input  logic [iwidth-1:0]   a_i,
    input  logic [iwidth-1:0]   b_i,
    output logic [2*iwidth-1:0] p_o
);

    logic [2*iwidth-1:0] a_ext;
    logic [2*iwidth-1:0] b_ext;

    // Widen before multiplying so no product bits are lost.
    assign a_ext = {{iwidth{1'b0}}, a_i};
    assign b_ext = {{iwidth{1'b0}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate: acc <= acc + a_i*b_i each edge, wrapping mod 2^swidth.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int unsigned iwidth = IWIDTH,
    parameter int unsigned swidth = SWIDTH
) (
    input  logic              clk,
    input  logic              rstn,   // active-high synchronous reset
    input  logic [iwidth-1:0] a_i,
    input  logic [iwidth-1:0] b_i,
    output logic [swidth-1:0] sum_o
);

    localparam int unsigned PWIDTH = prod_width(iwidth);

    if (swidth < PWIDTH) begin : g_width_check
        $error("mac_unit: swidth must be at least 2*iwidth");
    end

    logic [PWIDTH-1:0] prod;
    logic [swidth-1:0] prod_ext;
    logic [swidth-1:0] sum_d;
    logic [swidth-1:0] sum_q;

    mac_mult #(
        .iwidth (iwidth)
    ) u_mult (
        .a_i (a_i),
        .b_i (b_i),
        .p_o (prod)
    );

    always_comb begin
        prod_ext             = '0;
        prod_ext[PWIDTH-1:0] = prod;
        sum_d                = sum_q + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed literal checks plus a per-cycle model compare.
module tb_mac_unit;

    localparam int unsigned IW  = 4;
    localparam int unsigned SW  = 10;
    localparam int unsigned MOD = 1 << SW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [IW-1:0] a_i;
    logic [SW-1:0] sum_o;
    logic [IW-1:0] b_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: running sum of products modulo 2^SW, cleared by reset.
    int unsigned model_sum   = 0;
    bit          model_valid = 1'b0;

    mac_unit #(
        .iwidth (IW),
        .swidth (SW)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .a_i   (a_i),
        .b_i   (b_i),
        .sum_o (sum_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SW-1:0] act, input int unsigned exp);
        logic [SW-1:0] e;
        e = exp[SW-1:0];
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: sum_o=%0d expected %0d at t=%0t", name, act, e, $time);
        end
    endtask

    // Apply one edge's worth of inputs, then advance the model past that edge.
    task automatic step(input logic r, input int unsigned a, input int unsigned b);
        rstn = r;
        a_i  = a[IW-1:0];
        b_i  = b[IW-1:0];
        @(posedge clk);
        if (r) begin
            model_sum   = 0;
            model_valid = 1'b1;
        end else begin
            model_sum = (model_sum + a * b) % MOD;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (model_valid) check("model", sum_o, model_sum);
    end

    initial begin
        int unsigned ra;
        int unsigned rb;
        logic        rr;

        // Reset with non-zero operands present.
        step(1'b1, 5, 7);
        check("reset_edge1", sum_o, 0);
        step(1'b1, 5, 7);
        check("reset_edge2", sum_o, 0);

        step(1'b0, 1, 2);
        check("single_step1", sum_o, 2);
        step(1'b0, 2, 3);
        check("single_step2", sum_o, 8);

        // Hold 3*6 from zero, then zero operand holds the sum.
        step(1'b1, 0, 0);
        step(1'b0, 3, 6);
        check("hold_1", sum_o, 18);
        step(1'b0, 3, 6);
        check("hold_2", sum_o, 36);
        step(1'b0, 3, 6);
        check("hold_3", sum_o, 54);
        step(1'b0, 3, 6);
        check("hold_4", sum_o, 72);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 9);
            check("zero_hold", sum_o, 72);
        end

        // Mid-run reset discards the partial sum.
        step(1'b1, 4, 4);
        check("midrun_reset", sum_o, 0);
        step(1'b0, 4, 4);
        check("after_reset", sum_o, 16);

        // Wrap-around.
        step(1'b1, 0, 0);
        step(1'b0, 15, 15);
        check("wrap_1", sum_o, 225);
        step(1'b0, 15, 15);
        check("wrap_2", sum_o, 450);
        step(1'b0, 15, 15);
        check("wrap_3", sum_o, 675);
        step(1'b0, 15, 15);
        check("wrap_4", sum_o, 900);
        step(1'b0, 15, 15);
        check("wrap_5", sum_o, 101);

        // Exhaustive sweep of all operand pairs; total is 120*120 mod 1024.
        step(1'b1, 0, 0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(1'b0, a, b);
            end
        end
        check("sweep_final", sum_o, 64);

        // Random operands with occasional reset.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rr = ($urandom_range(0, 19) == 0);
            step(rr, ra, rb);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
